// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches through the memory controller and
// strobes {pc, inst} into IF/ID. Define ICACHE_EN to add a direct-mapped I-cache.
//
// state | meaning
// IDLE  | ready to start a fetch (or serve a cache hit)
// WAIT  | request outstanding, waiting for memDone_in
// HOLD  | word received while stalled, held until the stall releases
module inst_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          ICACHE_LINES = 128
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [5:0]  stall_in,
    input  logic        pcJump_in,
    input  logic [31:0] pcTarget_in,
    output logic        memReq_out,
    output logic [31:0] memAddr_out,
    input  logic        memDone_in,
    input  logic [31:0] memInst_in,
    output logic        instE_out,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        stallReq_out
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] held;
    logic        flush;
    logic [31:0] target;
    logic [31:0] pc_next;
    logic        stalled;
    logic        hit;
    logic [31:0] hit_data;
    logic        unused_bits;

    assign target       = {pcTarget_in[31:2], 2'b00};
    assign pc_next      = pc + 32'd4;
    assign stalled      = stall_in[0];
    assign stallReq_out = (state == WAIT);
    assign unused_bits  = ^{stall_in[5:1], pcTarget_in[1:0]};

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ICACHE_LINES-1:0] line_valid;
    logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
    logic [31:0]             line_data [ICACHE_LINES];
    logic [IDX_W-1:0]        pc_idx;
    logic [TAG_W-1:0]        pc_tag;
    logic [IDX_W-1:0]        fill_idx;
    logic                    fill;

    assign pc_idx   = pc[IDX_W+1:2];
    assign pc_tag   = pc[31:IDX_W+2];
    assign fill_idx = memAddr_out[IDX_W+1:2];
    // Every returned word fills its line, even one that is about to be discarded.
    assign fill     = (state == WAIT) && memDone_in;
    assign hit      = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
    assign hit_data = line_data[pc_idx];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            line_valid <= '0;
        end else if (fill) begin
            line_valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill) begin
            line_tag[fill_idx]  <= memAddr_out[31:IDX_W+2];
            line_data[fill_idx] <= memInst_in;
        end
    end
`else
    localparam int unused_lines = ICACHE_LINES;

    assign hit      = 1'b0;
    assign hit_data = 32'h0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            held        <= 32'h0;
            flush       <= 1'b0;
            memReq_out  <= 1'b0;
            memAddr_out <= 32'h0;
            instE_out   <= 1'b0;
            pc_out      <= 32'h0;
            inst_out    <= 32'h0;
        end else begin
            instE_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (pcJump_in) begin
                        pc <= target;
                    end else if (!stalled) begin
                        if (hit) begin
                            instE_out <= 1'b1;
                            pc_out    <= pc;
                            inst_out  <= hit_data;
                            pc        <= pc_next;
                        end else begin
                            memReq_out  <= 1'b1;
                            memAddr_out <= pc;
                            state       <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (pcJump_in) begin
                        pc <= target;
                    end
                    if (memDone_in) begin
                        memReq_out <= 1'b0;
                        state      <= IDLE;
                        if (flush || pcJump_in) begin
                            flush <= 1'b0;
                        end else if (stalled) begin
                            held  <= memInst_in;
                            state <= HOLD;
                        end else begin
                            instE_out <= 1'b1;
                            pc_out    <= pc;
                            inst_out  <= memInst_in;
                            pc        <= pc_next;
                        end
                    end else if (pcJump_in) begin
                        flush <= 1'b1;
                    end
                end
                HOLD: begin
                    if (pcJump_in) begin
                        pc    <= target;
                        state <= IDLE;
                    end else if (!stalled) begin
                        instE_out <= 1'b1;
                        pc_out    <= pc;
                        inst_out  <= held;
                        pc        <= pc_next;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a rule-level model checked every cycle plus directed scenarios
// with literal expectations. Define ICACHE_EN to also exercise the cache loop.
module tb_inst_fetch;

    localparam int LINES = 128;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [5:0]  stall_in = 6'h0;
    logic        pcJump_in = 1'b0;
    logic [31:0] pcTarget_in = 32'h0;
    logic        memReq_out;
    logic [31:0] memAddr_out;
    logic        memDone_in = 1'b0;
    logic [31:0] memInst_in = 32'h0;
    logic        instE_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        stallReq_out;

    always #5 clk_in = ~clk_in;

    inst_fetch #(.RESET_PC(32'h0), .ICACHE_LINES(LINES)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in),
        .pcJump_in(pcJump_in), .pcTarget_in(pcTarget_in),
        .memReq_out(memReq_out), .memAddr_out(memAddr_out),
        .memDone_in(memDone_in), .memInst_in(memInst_in),
        .instE_out(instE_out), .pc_out(pc_out), .inst_out(inst_out),
        .stallReq_out(stallReq_out)
    );

    int n_total = 0;
    int n_pass  = 0;
    int ncyc    = 0;
    bit check_on = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hC) return 32'h00100093;
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F1357;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, ncyc);
    endtask

    // Reference model: spec-level bookkeeping of the outstanding fetch and held word.
    logic [31:0] m_pc, m_held;
    bit          m_busy, m_doom, m_hold;
    logic        e_req, e_ie;
    logic [31:0] e_addr, e_pc, e_inst;
`ifdef ICACHE_EN
    logic [31:0] c_addr [int];
    logic [31:0] c_word [int];
`endif

    task automatic model_reset();
        m_pc = 32'h0; m_held = 32'h0; m_busy = 0; m_doom = 0; m_hold = 0;
        e_req = 0; e_ie = 0; e_addr = 32'h0; e_pc = 32'h0; e_inst = 32'h0;
`ifdef ICACHE_EN
        c_addr.delete();
        c_word.delete();
`endif
    endtask

    task automatic deliver(input logic [31:0] w);
        e_ie   = 1;
        e_pc   = m_pc;
        e_inst = w;
        m_pc   = m_pc + 32'd4;
    endtask

    task automatic model_step();
        logic        j, st, d, hit_now;
        logic [31:0] tgt;
        j   = pcJump_in;
        st  = stall_in[0];
        d   = memDone_in;
        tgt = pcTarget_in & 32'hFFFF_FFFC;
        e_ie = 0;
        hit_now = 0;
        if (m_busy) begin
            if (j) begin
                m_doom = 1;
                m_pc   = tgt;
            end
            if (d) begin
`ifdef ICACHE_EN
                c_addr[int'((e_addr >> 2) % LINES)] = e_addr;
                c_word[int'((e_addr >> 2) % LINES)] = memInst_in;
`endif
                m_busy = 0;
                e_req  = 0;
                if (m_doom) m_doom = 0;
                else if (st) begin
                    m_hold = 1;
                    m_held = memInst_in;
                end else deliver(memInst_in);
            end
        end else if (m_hold) begin
            if (j) begin
                m_hold = 0;
                m_pc   = tgt;
            end else if (!st) begin
                m_hold = 0;
                deliver(m_held);
            end
        end else if (j) begin
            m_pc = tgt;
        end else if (!st) begin
`ifdef ICACHE_EN
            if (c_addr.exists(int'((m_pc >> 2) % LINES)) && c_addr[int'((m_pc >> 2) % LINES)] == m_pc) begin
                hit_now = 1;
                deliver(c_word[int'((m_pc >> 2) % LINES)]);
            end
`endif
            if (!hit_now) begin
                m_busy = 1;
                e_req  = 1;
                e_addr = m_pc;
            end
        end
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk_in or posedge rst_in);
            if (rst_in) model_reset();
            else model_step();
            if (clk_in) ncyc++;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk_in);
            if (check_on) begin
                chk("cmp instE", instE_out, e_ie);
                chk("cmp memReq", memReq_out, e_req);
                chk("cmp memAddr", memAddr_out, e_addr);
                chk("cmp stallReq", stallReq_out, m_busy);
                chk("cmp pc_out", pc_out, e_pc);
                chk("cmp inst_out", inst_out, e_inst);
            end
        end
    end

    // Memory controller stand-in: answers each new request three cycles later.
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk_in);
            if (memDone_in) memDone_in = 1'b0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    memDone_in = 1'b1;
                    memInst_in = mem_word(memAddr_out);
                end
            end else if (memReq_out) cnt = 3;
        end
    end

    task automatic wait_req(input string name);
        bit seen_low;
        int k;
        seen_low = !memReq_out;
        k = 0;
        while (k < 60) begin
            @(negedge clk_in);
            k++;
            if (memReq_out && seen_low) break;
            if (!memReq_out) seen_low = 1;
        end
        chk({name, " req"}, memReq_out, 1);
    endtask

    task automatic wait_strobe(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk_in);
            k++;
        end while (!instE_out && k < 60);
        chk({name, " strobe"}, instE_out, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t0;
        #1 rst_in = 1'b1;
        check_on = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("reset pc_out", pc_out, 32'h0);
        chk("reset instE", instE_out, 0);
        chk("reset memReq", memReq_out, 0);
        chk("reset stallReq", stallReq_out, 0);
        rst_in = 1'b0;

        // Sequential fetches with three-cycle memory latency
        wait_req("t1");
        t0 = ncyc;
        chk("t1 stallReq in wait", stallReq_out, 1);
        chk("t1 addr0", memAddr_out, 32'h0);
        wait_strobe("t1a");
        chk("t1 pc0", pc_out, 32'h0);
        chk("t1 latency", ncyc - t0, 4);
        wait_strobe("t1b");
        chk("t1 pc4", pc_out, 32'h4);
        wait_strobe("t1c");
        chk("t1 pc8", pc_out, 32'h8);

        // Stall held across memDone
        wait_req("t2");
        chk("t2 addr", memAddr_out, 32'hC);
        repeat (3) @(negedge clk_in);
        stall_in = 6'h1;
        repeat (3) begin
            @(negedge clk_in);
            chk("t2 held no strobe", instE_out, 0);
        end
        stall_in = 6'h0;
        @(negedge clk_in);
        chk("t2 release strobe", instE_out, 1);
        chk("t2 inst", inst_out, 32'h00100093);
        chk("t2 pc", pc_out, 32'hC);

        // Jump in mid-WAIT discards the pending word
        wait_req("t3");
        @(negedge clk_in);
        pcJump_in = 1'b1;
        pcTarget_in = 32'h100;
        @(negedge clk_in);
        pcJump_in = 1'b0;
        wait_req("t3 redirect");
        chk("t3 addr", memAddr_out, 32'h100);
        wait_strobe("t3");
        chk("t3 pc", pc_out, 32'h100);
        chk("t3 inst", inst_out, mem_word(32'h100));

        // Jump coincident with memDone, unaligned target
        wait_req("t4");
        repeat (3) @(negedge clk_in);
        pcJump_in = 1'b1;
        pcTarget_in = 32'h203;
        @(negedge clk_in);
        pcJump_in = 1'b0;
        chk("t4 no strobe", instE_out, 0);
        wait_req("t4 redirect");
        chk("t4 addr", memAddr_out, 32'h200);
        wait_strobe("t4");
        chk("t4 pc", pc_out, 32'h200);

        // PC wrap at the top of the address space
        pcJump_in = 1'b1;
        pcTarget_in = 32'hFFFF_FFFF;
        @(negedge clk_in);
        pcJump_in = 1'b0;
        chk("t5 jump no req", memReq_out, 0);
        wait_req("t5");
        chk("t5 addr top", memAddr_out, 32'hFFFF_FFFC);
        wait_strobe("t5 top");
        chk("t5 pc top", pc_out, 32'hFFFF_FFFC);
`ifndef ICACHE_EN
        wait_req("t5 wrap");
        chk("t5 addr wrap", memAddr_out, 32'h0);
`endif
        wait_strobe("t5 wrap");
        chk("t5 pc wrap", pc_out, 32'h0);

        // Reset in the middle of WAIT; late memDone must be ignored
        pcJump_in = 1'b1;
        pcTarget_in = 32'h300;
        @(negedge clk_in);
        pcJump_in = 1'b0;
        wait_req("t7");
        chk("t7 addr", memAddr_out, 32'h300);
        @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        chk("t7 memReq async", memReq_out, 0);
        chk("t7 stallReq async", stallReq_out, 0);
        chk("t7 memAddr async", memAddr_out, 32'h0);
        chk("t7 pc_out async", pc_out, 32'h0);
        chk("t7 inst_out async", inst_out, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        stall_in = 6'h1;
        repeat (5) begin
            @(negedge clk_in);
            chk("t7 late done no req", memReq_out, 0);
            chk("t7 late done no strobe", instE_out, 0);
        end
        stall_in = 6'h0;
        wait_req("t7 restart");
        chk("t7 restart addr", memAddr_out, 32'h0);
        wait_strobe("t7");
        chk("t7 pc", pc_out, 32'h0);
        chk("t7 inst", inst_out, mem_word(32'h0));

`ifdef ICACHE_EN
        // Two-instruction loop at 0x40 served from the cache after the first pass
        pcJump_in = 1'b1;
        pcTarget_in = 32'h40;
        @(negedge clk_in);
        pcJump_in = 1'b0;
        for (int it = 0; it < 4; it++) begin
            wait_strobe("t6 a");
            chk("t6 pc 40", pc_out, 32'h40);
            t0 = ncyc;
            if (it > 0) chk("t6 no req a", memReq_out, 0);
            wait_strobe("t6 b");
            chk("t6 pc 44", pc_out, 32'h44);
            if (it > 0) chk("t6 back-to-back", ncyc - t0, 1);
            pcJump_in = 1'b1;
            pcTarget_in = 32'h40;
            @(negedge clk_in);
            pcJump_in = 1'b0;
            if (it > 0) chk("t6 no req jump", memReq_out, 0);
        end
`endif

        repeat (3) @(negedge clk_in);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
